// File: rtl/pvt_uart_cmd_deframer.sv
// UART 8N1(+parity) command deframer: header {type,addr} + per-type payload -> one command per handshake.
// Latency: SYNC_STAGES + frame time, cmd_valid right after the last stop sample; never stalls, overruns are dropped.
module pvt_uart_cmd_deframer #(
  parameter int          CLKS_PER_BIT = 1,
  parameter int          SYNC_STAGES  = 2,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int          PARITY       = 0,
  parameter int          DATA_W       = 32,
  parameter logic [23:0] LEN_MAP      = 24'h000224,
  parameter int          TIMEOUT_BITS = 16,
  localparam int         MAX_BYTES    = DATA_W / 8,
  localparam int         NB_W         = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_type,
  output logic [4:0]        cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic [NB_W-1:0]   cmd_nbytes,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              overrun_err
);

  localparam int HALF    = CLKS_PER_BIT / 2;
  localparam int HALF_M1 = (HALF > 0) ? HALF - 1 : 0;
  localparam int CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_LIM  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW      = (TO_LIM > 0) ? $clog2(TO_LIM + 1) : 1;

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PAR, B_STOP} bstate_t;
  typedef enum logic {P_HDR, P_PAY} pstate_t;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_sync_n = rst_q[1];

  logic rx_s;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = rx;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) sync_q <= '1;
        else             sync_q <= (sync_q << 1) | SYNC_STAGES'(rx);
      end
      assign rx_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  bstate_t           bstate;
  pstate_t           pstate;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              par_acc;
  logic [3:0]        bleft;
  logic [3:0]        pkt_len;
  logic [2:0]        pkt_type;
  logic [4:0]        pkt_addr;
  logic [DATA_W-1:0] pkt_data;
  logic [TW-1:0]     to_cnt;

  logic              tick, start_det, stop_ok, bad_frame, timeout_hit, pkt_done;
  logic [2:0]        raw_len;
  logic [3:0]        hdr_len;
  logic [DATA_W-1:0] pay_data;
  logic [2:0]        d_type;
  logic [4:0]        d_addr;
  logic [DATA_W-1:0] d_data;
  logic [3:0]        d_len;

  always_comb begin
    tick      = (cnt == '0);
    start_det = (bstate == B_IDLE) && !rx_s;
    stop_ok   = (bstate == B_STOP) && tick && rx_s;
    bad_frame = ((bstate == B_STOP) && tick && !rx_s) ||
                ((bstate == B_PAR) && tick && (par_acc ^ rx_s ^ (PARITY == 2)));
    raw_len   = LEN_MAP[int'(shreg[7:5]) * 3 +: 3];
    hdr_len   = ({1'b0, raw_len} > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : {1'b0, raw_len};
    pay_data  = (pkt_data << 8) | DATA_W'(shreg);
    timeout_hit = (TIMEOUT_BITS != 0) && (pstate == P_PAY) && (bstate == B_IDLE) &&
                  !start_det && (to_cnt == TW'(TO_LIM - 1));
    pkt_done  = stop_ok && (((pstate == P_HDR) && (hdr_len == 4'd0)) ||
                            ((pstate == P_PAY) && (bleft == 4'd1)));
    d_type    = (pstate == P_HDR) ? shreg[7:5] : pkt_type;
    d_addr    = (pstate == P_HDR) ? shreg[4:0] : pkt_addr;
    d_data    = (pstate == P_HDR) ? '0 : pay_data;
    d_len     = (pstate == P_HDR) ? 4'd0 : pkt_len;
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      bstate      <= B_IDLE;
      pstate      <= P_HDR;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'd0;
      par_acc     <= 1'b0;
      bleft       <= 4'd0;
      pkt_len     <= 4'd0;
      pkt_type    <= 3'd0;
      pkt_addr    <= 5'd0;
      pkt_data    <= '0;
      to_cnt      <= '0;
      cmd_valid   <= 1'b0;
      cmd_type    <= 3'd0;
      cmd_addr    <= 5'd0;
      cmd_data    <= '0;
      cmd_nbytes  <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;

      case (bstate)
        B_IDLE: if (!rx_s) begin
          par_acc <= 1'b0;
          bit_idx <= 3'd0;
          // With one clock per bit the detecting edge is already the start sample.
          if (HALF == 0) begin
            bstate <= B_DATA;
            cnt    <= CW'(CLKS_PER_BIT - 1);
          end else begin
            bstate <= B_START;
            cnt    <= CW'(HALF_M1);
          end
        end
        B_START: if (tick) begin
          if (rx_s) bstate <= B_IDLE;
          else begin
            bstate <= B_DATA;
            cnt    <= CW'(CLKS_PER_BIT - 1);
          end
        end
        B_DATA: if (tick) begin
          shreg   <= MSB_FIRST ? {shreg[6:0], rx_s} : {rx_s, shreg[7:1]};
          par_acc <= par_acc ^ rx_s;
          bit_idx <= bit_idx + 3'd1;
          cnt     <= CW'(CLKS_PER_BIT - 1);
          if (bit_idx == 3'd7) bstate <= (PARITY != 0) ? B_PAR : B_STOP;
        end
        B_PAR: if (tick) begin
          bstate <= B_STOP;
          cnt    <= CW'(CLKS_PER_BIT - 1);
        end
        B_STOP: if (tick) bstate <= B_IDLE;
        default: bstate <= B_IDLE;
      endcase

      if (start_det || pstate != P_PAY) to_cnt <= '0;
      else if (bstate == B_IDLE)        to_cnt <= to_cnt + 1'b1;

      if (bad_frame) begin
        frame_err <= 1'b1;
        bstate    <= B_IDLE;
        pstate    <= P_HDR;
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
        pstate      <= P_HDR;
      end else if (stop_ok) begin
        if (pstate == P_HDR) begin
          pkt_type <= shreg[7:5];
          pkt_addr <= shreg[4:0];
          pkt_data <= '0;
          pkt_len  <= hdr_len;
          bleft    <= hdr_len;
          if (hdr_len != 4'd0) pstate <= P_PAY;
        end else begin
          pkt_data <= pay_data;
          bleft    <= bleft - 4'd1;
          if (bleft == 4'd1) pstate <= P_HDR;
        end
      end

      // A held, unaccepted command wins; the newer packet is dropped.
      if (pkt_done) begin
        if (cmd_valid && !cmd_ready) overrun_err <= 1'b1;
        else begin
          cmd_valid  <= 1'b1;
          cmd_type   <= d_type;
          cmd_addr   <= d_addr;
          cmd_data   <= d_data;
          cmd_nbytes <= NB_W'(d_len);
        end
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pvt_uart_cmd_deframer.sv
// Scoreboard bench: instance A runs 1 clk/bit MSB-first no parity, instance B 16 clk/bit LSB-first even parity.
module tb_pvt_uart_cmd_deframer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rx_a = 1'b1, rdy_a = 1'b1, vld_a, ferr_a, terr_a, oerr_a;
  logic [2:0]  type_a, nb_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a;
  logic        rx_b = 1'b1, rdy_b = 1'b1, vld_b, ferr_b, terr_b, oerr_b;
  logic [2:0]  type_b, nb_b;
  logic [4:0]  addr_b;
  logic [31:0] data_b;

  pvt_uart_cmd_deframer #(.CLKS_PER_BIT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .cmd_valid(vld_a), .cmd_ready(rdy_a),
    .cmd_type(type_a), .cmd_addr(addr_a), .cmd_data(data_a), .cmd_nbytes(nb_a),
    .frame_err(ferr_a), .timeout_err(terr_a), .overrun_err(oerr_a));

  pvt_uart_cmd_deframer #(.CLKS_PER_BIT(16), .PARITY(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .cmd_valid(vld_b), .cmd_ready(rdy_b),
    .cmd_type(type_b), .cmd_addr(addr_b), .cmd_data(data_b), .cmd_nbytes(nb_b),
    .frame_err(ferr_b), .timeout_err(terr_b), .overrun_err(oerr_b));

  typedef struct packed {
    logic [2:0]  t;
    logic [4:0]  a;
    logic [31:0] d;
    logic [2:0]  n;
  } cmd_t;

  cmd_t exp_a[$];
  cmd_t exp_b[$];
  int n_vec = 0, n_bad = 0;
  int fe_a = 0, te_a = 0, oe_a = 0, fe_b = 0, te_b = 0, oe_b = 0;
  int f0, t0, o0, k;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ferr_a) fe_a++;
    if (terr_a) te_a++;
    if (oerr_a) oe_a++;
    if (vld_a && rdy_a) begin : mon_a
      cmd_t e;
      if (exp_a.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL cmd_a: got t=%0d a=%0d d=%h n=%0d, required no command", type_a, addr_a, data_a, nb_a);
      end else begin
        e = exp_a.pop_front();
        check("cmd_a", {type_a, addr_a, data_a, nb_a}, e);
      end
    end
  end

  always @(negedge clk) begin
    if (ferr_b) fe_b++;
    if (terr_b) te_b++;
    if (oerr_b) oe_b++;
    if (vld_b && rdy_b) begin : mon_b
      cmd_t e;
      if (exp_b.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL cmd_b: got t=%0d a=%0d d=%h n=%0d, required no command", type_b, addr_b, data_b, nb_b);
      end else begin
        e = exp_b.pop_front();
        check("cmd_b", {type_b, addr_b, data_b, nb_b}, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic set_rx(int w, logic v);
    if (w == 0) rx_a = v;
    else        rx_b = v;
  endtask

  task automatic send_byte(int w, logic [7:0] b, logic flip_par = 1'b0, logic bad_stop = 1'b0);
    int cpb;
    cpb = (w == 0) ? 1 : 16;
    set_rx(w, 1'b0);
    repeat (cpb) tick();
    for (int i = 0; i < 8; i++) begin
      set_rx(w, (w == 0) ? b[7-i] : b[i]);
      repeat (cpb) tick();
    end
    if (w == 1) begin
      set_rx(w, (^b) ^ flip_par);
      repeat (cpb) tick();
    end
    set_rx(w, ~bad_stop);
    repeat (cpb) tick();
    set_rx(w, 1'b1);
  endtask

  task automatic send_pkt(int w, int n, logic [39:0] bytes);
    for (int i = 0; i < n; i++) send_byte(w, bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic push(int w, logic [2:0] t, logic [4:0] a, logic [31:0] d, logic [2:0] n);
    cmd_t c;
    c = '{t: t, a: a, d: d, n: n};
    if (w == 0) exp_a.push_back(c);
    else        exp_b.push_back(c);
  endtask

  task automatic drain(int w, string name);
    int j;
    j = 0;
    while (((w == 0) ? exp_a.size() : exp_b.size()) != 0 && j < 500) begin
      tick();
      j++;
    end
    check(name, (w == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  initial begin
    idle(3);
    check("reset_a", {vld_a, type_a, addr_a, data_a, nb_a, ferr_a, terr_a, oerr_a}, 0);
    check("reset_b", {vld_b, type_b, addr_b, data_b, nb_b, ferr_b, terr_b, oerr_b}, 0);
    rst_n = 1'b1;
    idle(5);

    // Four-byte write, then zero- and one-byte commands.
    push(0, 3'd0, 5'd3, 32'h10101010, 3'd4);
    send_pkt(0, 5, 40'h03_10101010);
    drain(0, "t1_drain");
    push(0, 3'd2, 5'd0, 32'h0, 3'd0);
    send_pkt(0, 1, 40'h40);
    drain(0, "t2a_drain");
    push(0, 3'd3, 5'd1, 32'h1, 3'd1);
    send_pkt(0, 2, 40'h61_01);
    drain(0, "t2b_drain");

    // Bad stop bit on the third payload byte kills the packet.
    f0 = fe_a;
    send_pkt(0, 3, 40'h03_1122);
    send_byte(0, 8'h33, 1'b0, 1'b1);
    idle(10);
    check("t4_frame_err", fe_a - f0, 1);
    push(0, 3'd3, 5'd9, 32'h5E, 3'd1);
    send_pkt(0, 2, 40'h69_5E);
    drain(0, "t4_drain");

    // Parity flipped on the first payload byte.
    f0 = fe_b;
    send_byte(1, 8'h25);
    send_byte(1, 8'hA5, 1'b1);
    idle(40);
    check("t3_frame_err", fe_b - f0, 1);
    check("t3_no_valid", vld_b, 0);
    push(1, 3'd1, 5'd5, 32'hA55A3CC3, 3'd4);
    send_pkt(1, 5, 40'h25_A55A3CC3);
    drain(1, "t3_drain");

    // Stall after two of four payload bytes.
    t0 = te_b;
    send_pkt(1, 3, 40'h00_1122);
    k = 0;
    while (te_b == t0 && k < 400) begin
      tick();
      k++;
    end
    check("t5_timeout_window", (k >= 200 && k <= 300), 1);
    idle(300);
    check("t5_timeout_once", te_b - t0, 1);
    push(1, 3'd0, 5'd0, 32'hDEADBEEF, 3'd4);
    send_pkt(1, 5, 40'h00_DEADBEEF);
    drain(1, "t5_drain");

    // Backpressure across two packets.
    rdy_b = 1'b0;
    o0 = oe_b;
    push(1, 3'd3, 5'd4, 32'h77, 3'd1);
    send_pkt(1, 2, 40'h64_77);
    send_pkt(1, 1, 40'h40);
    idle(20);
    check("t6_overrun", oe_b - o0, 1);
    check("t6_held", {vld_b, type_b, addr_b, data_b, nb_b}, {1'b1, 3'd3, 5'd4, 32'h77, 3'd1});
    rdy_b = 1'b1;
    drain(1, "t6_drain");

    // One-cycle low glitch on an idle line.
    f0 = fe_b;
    rx_b = 1'b0;
    tick();
    rx_b = 1'b1;
    idle(60);
    check("t6_glitch_ferr", fe_b - f0, 0);
    check("t6_glitch_valid", vld_b, 0);

    // Reset mid-byte while a command is pending.
    rdy_b = 1'b0;
    send_pkt(1, 1, 40'h40);
    idle(5);
    check("t6_pending", vld_b, 1);
    rx_b = 1'b0;
    idle(40);
    rst_n = 1'b0;
    tick();
    check("t6_reset_out", {vld_b, type_b, addr_b, data_b, nb_b, ferr_b, terr_b, oerr_b}, 0);
    rx_b = 1'b1;
    rdy_b = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    push(1, 3'd1, 5'd2, 32'h12345678, 3'd4);
    send_pkt(1, 5, 40'h22_12345678);
    drain(1, "t6_reset_drain");

    check("a_no_timeout", te_a, 0);
    check("a_no_overrun", oe_a, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
